decode_ctrl_stage: RTL

//  Registered ID-stage control decoder for the 5-stage RV32I pipeline; successor to the combinational main decoder.

---
 rtl/decode_ctrl_stage.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage
//   Registered ID-stage control decoder for the 5-stage RV32I pipeline. It decodes
//   opcode/funct3/funct7 into a control bundle and holds it in a one-entry output
//   register. Around that register it provides a valid/ready handshake, load-use
//   hazard bubbles, flush, and a saturating count of illegal instructions.
// Parameters
//   EN_MULDIV  1: OP with funct7=0000001 decodes as MULDIV; 0: that encoding is illegal
//   ILL_CNT_W  width of the illegal-instruction counter
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        handshake with the IF/ID register; instr is the word offered
//   flush                    redirect: kills the held bundle and the incoming instr
//   ex_mem_read, ex_rd       load-in-EX information for load-use detection
//   out_valid/out_ready      handshake with the ID/EX register (out_valid=0 is a bubble)
//   reg_write..jalr          registered control bundle
//   illegal                  held instr is illegal (all other controls are 0)
//   ill_count                saturating count of accepted illegal instrs
module decode_ctrl_stage #(
  parameter bit          EN_MULDIV = 1'b0,
  parameter int unsigned ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr,
  input  logic                 flush,
  input  logic                 ex_mem_read,
  input  logic [4:0]           ex_rd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 reg_write,
  output logic                 mem_write,
  output logic                 mem_read,
  output logic                 alu_src,
  output logic [1:0]           result_src,
  output logic [2:0]           branch,
  output logic [2:0]           imm_src,
  output logic [1:0]           alu_op,
  output logic                 jalr,
  output logic                 illegal,
  output logic [ILL_CNT_W-1:0] ill_count
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef struct packed {
    logic       regWrite;
    logic       memWrite;
    logic       memRead;
    logic       aluSrc;
    logic [1:0] resultSrc;
    logic [2:0] branch;
    logic [2:0] immSrc;
    logic [1:0] aluOp;
    logic       jalr;
    logic       illegal;
  } ctrl_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1;
  logic [4:0] rs2;
  ctrl_t      dec;
  ctrl_t      held;
  logic       rs1Used;
  logic       rs2Used;
  logic       hazard;
  logic       regFree;
  logic       accept;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  always_comb begin
    dec     = '0;
    rs1Used = 1'b0;
    rs2Used = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        rs1Used       = 1'b1;
        dec.regWrite  = 1'b1;
        dec.memRead   = 1'b1;
        dec.aluSrc    = 1'b1;
        dec.resultSrc = 2'd1;
      end
      OPC_STORE: begin
        rs1Used      = 1'b1;
        rs2Used      = 1'b1;
        dec.memWrite = 1'b1;
        dec.aluSrc   = 1'b1;
        dec.immSrc   = 3'd1;
      end
      OPC_OP: begin
        rs1Used = 1'b1;
        rs2Used = 1'b1;
        if (funct7 == 7'h00 || (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          dec.regWrite = 1'b1;
          dec.aluOp    = 2'd2;
        end else if (funct7 == 7'h01 && EN_MULDIV == 1'b1) begin
          dec.regWrite = 1'b1;
          dec.aluOp    = 2'd3;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OPC_OPIMM: begin
        rs1Used      = 1'b1;
        dec.regWrite = 1'b1;
        dec.aluSrc   = 1'b1;
        dec.aluOp    = 2'd2;
      end
      OPC_BRANCH: begin
        rs1Used    = 1'b1;
        rs2Used    = 1'b1;
        dec.aluOp  = 2'd1;
        dec.immSrc = 3'd2;
        case (funct3)
          3'b000:  dec.branch = 3'd1;
          3'b001:  dec.branch = 3'd2;
          3'b100:  dec.branch = 3'd3;
          3'b101:  dec.branch = 3'd4;
          3'b110:  dec.branch = 3'd5;
          3'b111:  dec.branch = 3'd6;
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_JAL: begin
        dec.regWrite  = 1'b1;
        dec.resultSrc = 2'd2;
        dec.branch    = 3'd7;
        dec.immSrc    = 3'd4;
      end
      OPC_JALR: begin
        rs1Used = 1'b1;
        if (funct3 == 3'b000) begin
          dec.regWrite  = 1'b1;
          dec.resultSrc = 2'd2;
          dec.branch    = 3'd7;
          dec.jalr      = 1'b1;
          dec.aluSrc    = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        dec.regWrite  = 1'b1;
        dec.resultSrc = 2'd3;
        dec.immSrc    = 3'd3;
      end
      default: dec.illegal = 1'b1;
    endcase
    // An illegal instr carries only the illegal flag downstream.
    if (dec.illegal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  assign hazard  = in_valid && ex_mem_read && (ex_rd != 5'd0) &&
                   ((ex_rd == rs1 && rs1Used) || (ex_rd == rs2 && rs2Used));
  assign regFree = !out_valid || out_ready;
  // Flush raises in_ready so IF/ID can drain; the word itself is discarded.
  assign in_ready = flush ? 1'b1 : (regFree && !hazard);
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      held      <= '0;
      ill_count <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      held      <= '0;
    end else if (regFree) begin
      if (accept) begin
        out_valid <= 1'b1;
        held      <= dec;
        if (dec.illegal && ill_count != '1) begin
          ill_count <= ill_count + ILL_CNT_W'(1);
        end
      end else begin
        out_valid <= 1'b0;
        held      <= '0;
      end
    end
  end

  assign reg_write  = held.regWrite;
  assign mem_write  = held.memWrite;
  assign mem_read   = held.memRead;
  assign alu_src    = held.aluSrc;
  assign result_src = held.resultSrc;
  assign branch     = held.branch;
  assign imm_src    = held.immSrc;
  assign alu_op     = held.aluOp;
  assign jalr       = held.jalr;
  assign illegal    = held.illegal;

endmodule
